// File: rtl/core_mem_np_if.sv
// Membus bundle between up to four processor ports and one core memory module.
// Every signal is packed per port: port i owns bit i, sel[4*i +: 4], ma[ADDR_W*i +: ADDR_W], mb_*[36*i +: 36].
interface core_mem_np_if #(
   parameter int NPORTS = 4,
   parameter int ADDR_W = 15
);
   logic [NPORTS-1:0]        rq_cyc;
   logic [NPORTS-1:0]        rd_rq;
   logic [NPORTS-1:0]        wr_rq;
   logic [NPORTS-1:0]        fmc_select;
   logic [4*NPORTS-1:0]      sel;
   logic [ADDR_W*NPORTS-1:0] ma;
   logic [NPORTS-1:0]        wr_rs;
   logic [36*NPORTS-1:0]     mb_in;
   logic [NPORTS-1:0]        addr_ack;
   logic [NPORTS-1:0]        rd_rs;
   logic [36*NPORTS-1:0]     mb_out;

   modport master (
      output rq_cyc, rd_rq, wr_rq, fmc_select, sel, ma, wr_rs, mb_in,
      input  addr_ack, rd_rs, mb_out
   );

   modport slave (
      input  rq_cyc, rd_rq, wr_rq, fmc_select, sel, ma, wr_rs, mb_in,
      output addr_ack, rd_rs, mb_out
   );
endinterface

// File: rtl/core_mem_np.sv
// Multi-port core memory: one cycle at a time, addr_ack one clock after grant, rd_rs RD_CYC clocks later.
// Losing ports are never latched; they just keep requesting until granted.
module core_mem_np #(
   parameter int          NPORTS = 4,
   parameter int          ADDR_W = 15,
   parameter logic [15:0] MEMSEL = 16'h0000,
   parameter int          RD_CYC = 4,
   parameter int          WR_CYC = 4,
   parameter bit          ARB_RR = 1'b0
) (
   input logic          clk,
   input logic          reset,
   input logic          power,
   core_mem_np_if.slave membus
);
   localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int CMAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, ACK, READ, RDRS, WWAIT, WRITE} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     grant_q, grant_d;
   logic [PW-1:0]     last_q, last_d;
   logic [ADDR_W-1:0] ma_q, ma_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [35:0]       mb_q, mb_d;
   logic [35:0]       rd_dat_q, rd_dat_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [NPORTS-1:0] elig;
   logic              any_elig;
   logic [PW-1:0]     win;
   logic              wr_rs_g;
   logic [35:0]       mb_in_g;
   logic              wr_en;
   int                j;

   // Not reset: contents survive reset and are preloaded from outside.
   logic [35:0] core [0:(2**ADDR_W)-1];

   always_comb begin
      elig = '0;
      for (int i = 0; i < NPORTS; i++) begin
         elig[i] = power && membus.rq_cyc[i] && (membus.rd_rq[i] || membus.wr_rq[i]) &&
                   !membus.fmc_select[i] && (membus.sel[4*i +: 4] == MEMSEL[4*i +: 4]);
      end
   end

   always_comb begin
      any_elig = 1'b0;
      win      = '0;
      j        = 0;
      if (ARB_RR) begin
         // Search starts just after the previous winner and wraps.
         for (int k = 1; k <= NPORTS; k++) begin
            j = int'(last_q) + k;
            if (j >= NPORTS) j = j - NPORTS;
            for (int i = 0; i < NPORTS; i++) begin
               if (!any_elig && (j == i) && elig[i]) begin
                  any_elig = 1'b1;
                  win      = PW'(i);
               end
            end
         end
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (!any_elig && elig[i]) begin
               any_elig = 1'b1;
               win      = PW'(i);
            end
         end
      end
   end

   always_comb begin
      wr_rs_g = 1'b0;
      mb_in_g = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (grant_q == PW'(i)) begin
            wr_rs_g = membus.wr_rs[i];
            mb_in_g = membus.mb_in[36*i +: 36];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      ma_d     = ma_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      mb_d     = mb_q;
      cnt_d    = cnt_q;
      rd_dat_d = rd_dat_q;
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               state_d = ACK;
               grant_d = win;
               last_d  = win;
               for (int i = 0; i < NPORTS; i++) begin
                  if (win == PW'(i)) begin
                     ma_d = membus.ma[ADDR_W*i +: ADDR_W];
                     rd_d = membus.rd_rq[i];
                     wr_d = membus.wr_rq[i];
                  end
               end
            end
         end
         ACK: begin
            if (!rd_q) begin
               state_d = WWAIT;
            end else if (RD_CYC > 1) begin
               state_d = READ;
               cnt_d   = CW'(RD_CYC - 1);
            end else begin
               state_d  = RDRS;
               rd_dat_d = core[ma_q];
            end
         end
         READ: begin
            if (cnt_q == CW'(1)) begin
               state_d  = RDRS;
               rd_dat_d = core[ma_q];
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RDRS: state_d = wr_q ? WWAIT : IDLE;
         WWAIT: begin
            if (wr_rs_g) begin
               state_d = WRITE;
               mb_d    = mb_in_g;
               cnt_d   = CW'(WR_CYC);
            end
         end
         WRITE: begin
            if (cnt_q == CW'(1)) state_d = IDLE;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // The array is written only on the first WRITE clock.
   assign wr_en = (state_q == WRITE) && (cnt_q == CW'(WR_CYC));

   always_comb begin
      membus.addr_ack = '0;
      membus.rd_rs    = '0;
      membus.mb_out   = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (grant_q == PW'(i)) begin
            membus.addr_ack[i] = (state_q == ACK);
            if (state_q == RDRS) begin
               membus.rd_rs[i]         = 1'b1;
               membus.mb_out[36*i +: 36] = rd_dat_q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= PW'(NPORTS - 1);
         ma_q     <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         mb_q     <= '0;
         cnt_q    <= '0;
         rd_dat_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         ma_q     <= ma_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         mb_q     <= mb_d;
         cnt_q    <= cnt_d;
         rd_dat_q <= rd_dat_d;
      end
   end

   always @(posedge clk) begin
      if (wr_en) core[ma_q] <= mb_q;
   end
endmodule

// File: tb/tb_core_mem_np.sv
// Scoreboard bench: dut_a is fixed-priority with MEMSEL p0=1, dut_b is round-robin.
// Stimulus queues expected acks/read data; a negedge monitor pops and compares.
module tb_core_mem_np;
   localparam int NP  = 4;
   localparam int AW  = 15;
   localparam int RDC = 4;
   localparam int WRC = 4;

   typedef struct {int port; int cyc;} ack_ent_t;
   typedef struct {int port; logic [35:0] dat;} rd_ent_t;

   logic clk = 1'b0;
   logic reset;
   logic power;
   always #5 clk = ~clk;

   core_mem_np_if #(.NPORTS(NP), .ADDR_W(AW)) bus_a ();
   core_mem_np_if #(.NPORTS(NP), .ADDR_W(AW)) bus_b ();

   core_mem_np #(.NPORTS(NP), .ADDR_W(AW), .MEMSEL(16'h0001), .RD_CYC(RDC), .WR_CYC(WRC),
                 .ARB_RR(1'b0)) dut_a (.clk(clk), .reset(reset), .power(power), .membus(bus_a));
   core_mem_np #(.NPORTS(NP), .ADDR_W(AW), .MEMSEL(16'h0001), .RD_CYC(RDC), .WR_CYC(WRC),
                 .ARB_RR(1'b1)) dut_b (.clk(clk), .reset(reset), .power(power), .membus(bus_b));

   ack_ent_t ack_qa[$], ack_qb[$];
   rd_ent_t  rd_qa[$],  rd_qb[$];
   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int leak_a = 0, leak_b = 0;
   int last_ack_a = 0, last_ack_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0o, expected %0o (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic exp_ack(input int d, input int p, input int c);
      ack_ent_t e;
      e.port = p;
      e.cyc  = c;
      if (d == 0) ack_qa.push_back(e);
      else        ack_qb.push_back(e);
   endtask

   task automatic exp_rd(input int d, input int p, input logic [35:0] dat);
      rd_ent_t e;
      e.port = p;
      e.dat  = dat;
      if (d == 0) rd_qa.push_back(e);
      else        rd_qb.push_back(e);
   endtask

   function automatic int low_idx(input logic [NP-1:0] v);
      int r = 0;
      for (int i = NP - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic mon(input int d, input logic [NP-1:0] ack, input logic [NP-1:0] rds,
                      input logic [36*NP-1:0] mbo);
      ack_ent_t ae;
      rd_ent_t  re;
      int p;
      int la;
      logic [36*NP-1:0] rest;
      rest = mbo;
      la = (d == 0) ? last_ack_a : last_ack_b;
      if (ack != '0) begin
         p = low_idx(ack);
         chk("ack_onehot", $countones(ack), 1);
         if ((d == 0 && ack_qa.size() > 0) || (d == 1 && ack_qb.size() > 0)) begin
            if (d == 0) ae = ack_qa.pop_front();
            else        ae = ack_qb.pop_front();
            chk("ack_port", p, ae.port);
            if (ae.cyc >= 0) chk("ack_cycle", cyc, ae.cyc);
         end else begin
            chk("ack_unexpected", ack, 0);
         end
         if (d == 0) last_ack_a = cyc;
         else        last_ack_b = cyc;
      end
      if (rds != '0) begin
         p = low_idx(rds);
         if ((d == 0 && rd_qa.size() > 0) || (d == 1 && rd_qb.size() > 0)) begin
            if (d == 0) re = rd_qa.pop_front();
            else        re = rd_qb.pop_front();
            chk("rd_port", p, re.port);
            chk("rd_data", mbo[36*p +: 36], re.dat);
            chk("rd_latency", cyc - la, RDC);
         end else begin
            chk("rd_unexpected", rds, 0);
         end
         rest[36*p +: 36] = '0;
      end
      if (rest != '0) begin
         if (d == 0) leak_a++;
         else        leak_b++;
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon(0, bus_a.addr_ack, bus_a.rd_rs, bus_a.mb_out);
         mon(1, bus_b.addr_ack, bus_b.rd_rs, bus_b.mb_out);
      end
   end

   function automatic logic [3:0] msel(input int p);
      return (p == 0) ? 4'h1 : 4'h0;
   endfunction

   task automatic a_set(input int p, input bit on, input bit rd, input bit wr,
                        input logic [AW-1:0] ma, input logic [3:0] sel);
      bus_a.rq_cyc[p]       = on;
      bus_a.rd_rq[p]        = rd;
      bus_a.wr_rq[p]        = wr;
      bus_a.ma[AW*p +: AW]  = ma;
      bus_a.sel[4*p +: 4]   = sel;
   endtask

   function automatic logic out_bit(input int d, input bit rdrs, input int p);
      if (d == 0) return rdrs ? bus_a.rd_rs[p] : bus_a.addr_ack[p];
      return rdrs ? bus_b.rd_rs[p] : bus_b.addr_ack[p];
   endfunction

   // Bounded wait for addr_ack (rdrs=0) or rd_rs (rdrs=1) on port p.
   task automatic wait_out(input int d, input bit rdrs, input int p);
      int  n = 0;
      logic got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = out_bit(d, rdrs, p);
      end
      if (!got) chk(rdrs ? "rd_rs_wait" : "ack_wait", 0, 1);
   endtask

   task automatic count_acks(input int d, input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if ((d == 0 && bus_a.addr_ack != '0) || (d == 1 && bus_b.addr_ack != '0)) n++;
      end
   endtask

   task automatic drain(input int d);
      int n = 0;
      int pend;
      pend = (d == 0) ? ack_qa.size() + rd_qa.size() : ack_qb.size() + rd_qb.size();
      while (pend != 0 && n < 60) begin
         @(negedge clk);
         n++;
         pend = (d == 0) ? ack_qa.size() + rd_qa.size() : ack_qb.size() + rd_qb.size();
      end
      chk(d == 0 ? "drain_a" : "drain_b", pend, 0);
   endtask

   task automatic a_read(input int p, input logic [AW-1:0] ma, input logic [35:0] dat, input int ack_cyc);
      exp_ack(0, p, ack_cyc);
      exp_rd(0, p, dat);
      a_set(p, 1'b1, 1'b1, 1'b0, ma, msel(p));
      wait_out(0, 1'b0, p);
      a_set(p, 1'b0, 1'b0, 1'b0, '0, msel(p));
      wait_out(0, 1'b1, p);
      @(negedge clk);
   endtask

   // Write (or read-modify-write) followed by a read-back whose ack time proves the WR_CYC hold.
   task automatic a_write(input int p, input logic [AW-1:0] ma, input logic [35:0] dat,
                          input bit rmw, input logic [35:0] old);
      int w;
      int q;
      q = (p + 1) % NP;
      exp_ack(0, p, cyc + 1);
      if (rmw) exp_rd(0, p, old);
      a_set(p, 1'b1, rmw, 1'b1, ma, msel(p));
      wait_out(0, 1'b0, p);
      a_set(p, 1'b0, 1'b0, 1'b0, '0, msel(p));
      if (rmw) begin
         @(negedge clk);
         bus_a.wr_rs[p] = 1'b1;
         bus_a.mb_in[36*p +: 36] = 36'o666666666666;
         @(negedge clk);
         bus_a.wr_rs[p] = 1'b0;
         wait_out(0, 1'b1, p);
      end
      @(negedge clk);
      bus_a.wr_rs[q] = 1'b1;
      bus_a.mb_in[36*q +: 36] = 36'o555;
      @(negedge clk);
      bus_a.wr_rs[q] = 1'b0;
      bus_a.wr_rs[p] = 1'b1;
      bus_a.mb_in[36*p +: 36] = dat;
      w = cyc;
      @(negedge clk);
      bus_a.wr_rs[p] = 1'b0;
      bus_a.mb_in = '0;
      a_read(p, ma, dat, w + WRC + 2);
   endtask

   initial begin
      int n;
      int k;
      reset = 1'b1;
      power = 1'b1;
      bus_a.rq_cyc = '0; bus_a.rd_rq = '0; bus_a.wr_rq = '0; bus_a.fmc_select = '0;
      bus_a.sel = '0; bus_a.ma = '0; bus_a.wr_rs = '0; bus_a.mb_in = '0;
      bus_b.rq_cyc = '0; bus_b.rd_rq = '0; bus_b.wr_rq = '0; bus_b.fmc_select = '0;
      bus_b.sel = '0; bus_b.ma = '0; bus_b.wr_rs = '0; bus_b.mb_in = '0;
      dut_a.core[15'o141] = 36'd1;
      dut_a.core[15'o200] = 36'o777740000100;
      dut_a.core[15'o10]  = 36'o11;
      dut_a.core[15'o20]  = 36'o22;
      dut_b.core[15'o10]  = 36'o11;
      dut_b.core[15'o20]  = 36'o22;

      repeat (3) @(negedge clk);
      chk("rst_ack_a", bus_a.addr_ack, 0);
      chk("rst_rdrs_a", bus_a.rd_rs, 0);
      chk("rst_mb_a", bus_a.mb_out != '0, 0);
      chk("rst_ack_b", bus_b.addr_ack, 0);
      chk("rst_rdrs_b", bus_b.rd_rs, 0);
      reset = 1'b0;
      @(negedge clk);

      a_read(0, 15'o141, 36'd1, cyc + 1);
      a_write(0, 15'o300, 36'o123456111222, 1'b0, 36'd0);
      a_write(0, 15'o200, 36'o1, 1'b1, 36'o777740000100);

      a_set(0, 1'b1, 1'b1, 1'b0, 15'o141, 4'h0);
      count_acks(0, 20, n);
      chk("sel_mismatch", n, 0);
      a_set(0, 1'b1, 1'b1, 1'b0, 15'o141, 4'h1);
      bus_a.fmc_select[0] = 1'b1;
      count_acks(0, 20, n);
      chk("fmc_select", n, 0);
      bus_a.fmc_select[0] = 1'b0;
      power = 1'b0;
      count_acks(0, 20, n);
      chk("power_off", n, 0);
      a_set(0, 1'b0, 1'b0, 1'b0, '0, 4'h1);
      power = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         exp_ack(0, 1, -1);
         exp_rd(0, 1, 36'o11);
      end
      a_set(1, 1'b1, 1'b1, 1'b0, 15'o10, 4'h0);
      a_set(3, 1'b1, 1'b1, 1'b0, 15'o20, 4'h0);
      n = 0; k = 0;
      while (n < 3 && k < 200) begin
         @(negedge clk);
         k++;
         if (bus_a.addr_ack != '0) n++;
      end
      a_set(1, 1'b0, 1'b0, 1'b0, '0, 4'h0);
      a_set(3, 1'b0, 1'b0, 1'b0, '0, 4'h0);
      chk("arb_fixed_acks", n, 3);
      drain(0);
      @(negedge clk);

      // Reset while in ACK (dly 0) and while in READ (dly 2).
      for (int dly = 0; dly <= 2; dly += 2) begin
         exp_ack(0, 0, cyc + 1);
         a_set(0, 1'b1, 1'b1, 1'b0, 15'o141, 4'h1);
         wait_out(0, 1'b0, 0);
         a_set(0, 1'b0, 1'b0, 1'b0, '0, 4'h1);
         repeat (dly) @(negedge clk);
         #1;
         reset = 1'b1;
         #1;
         chk("midrst_ack", bus_a.addr_ack, 0);
         chk("midrst_rdrs", bus_a.rd_rs, 0);
         chk("midrst_mb", bus_a.mb_out != '0, 0);
         repeat (2) @(negedge clk);
         reset = 1'b0;
         repeat (10) @(negedge clk);
         a_read(0, 15'o141, 36'd1, cyc + 1);
      end

      exp_ack(1, 1, -1); exp_rd(1, 1, 36'o11);
      exp_ack(1, 3, -1); exp_rd(1, 3, 36'o22);
      exp_ack(1, 1, -1); exp_rd(1, 1, 36'o11);
      exp_ack(1, 3, -1); exp_rd(1, 3, 36'o22);
      bus_b.rq_cyc[1] = 1'b1; bus_b.rd_rq[1] = 1'b1; bus_b.ma[AW*1 +: AW] = 15'o10;
      bus_b.rq_cyc[3] = 1'b1; bus_b.rd_rq[3] = 1'b1; bus_b.ma[AW*3 +: AW] = 15'o20;
      n = 0; k = 0;
      while (n < 4 && k < 200) begin
         @(negedge clk);
         k++;
         if (bus_b.addr_ack != '0) n++;
      end
      bus_b.rq_cyc = '0;
      bus_b.rd_rq  = '0;
      chk("arb_rr_acks", n, 4);
      drain(1);
      drain(0);

      repeat (5) @(negedge clk);
      chk("mb_out_idle_a", leak_a, 0);
      chk("mb_out_idle_b", leak_b, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
